// File: rtl/mem_access.sv
// mem_access: memory stage sitting after execute.
// Drives a single-outstanding req/ack data bus and handles byte-lane steering
// and load extension. It also runs a bus timeout and reports errors.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses (cause 10) instead of silently aligning them.
module mem_access #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_addr,
    input  logic [WIDTH-1:0] ex_wdata,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_read,
    input  logic             ex_write,
    output logic             ex_ready,
    output logic             stall,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic [3:0]       bus_wstrb,
    input  logic             bus_ack,
    input  logic [WIDTH-1:0] bus_rdata,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data,
    output logic             err,
    output logic [1:0]       err_cause
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       cause_q, cause_d;

    logic [WIDTH-1:0] wdata_rep;
    logic [3:0]       wstrb_new;
    logic             f3_legal;
    logic             misalign;
    logic [WIDTH-1:0] rdata_shift;
    logic [15:0]      rhalf;
    logic [WIDTH-1:0] load_data;

    // Store data replicated across all lanes: byte x4, half x2 or full word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_rep[gi*8 +: 8] =
                (ex_funct3[1:0] == 2'b00) ? ex_wdata[7:0] :
                (ex_funct3[1:0] == 2'b01) ? ex_wdata[(gi%2)*8 +: 8] :
                                            ex_wdata[gi*8 +: 8];
        end
    endgenerate

    // Byte enables and funct3 legality/alignment checks for the incoming request.
    always_comb begin
        wstrb_new = 4'b1111;
        case (ex_funct3[1:0])
            2'b00:   wstrb_new = 4'b0001 << ex_addr[1:0];
            2'b01:   wstrb_new = 4'b0011 << {ex_addr[1], 1'b0};
            default: wstrb_new = 4'b1111;
        endcase
        if (ex_write)
            f3_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) ||
                       (ex_funct3 == 3'b010);
        else
            f3_legal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) ||
                       (ex_funct3 == 3'b010) || (ex_funct3 == 3'b100) ||
                       (ex_funct3 == 3'b101);
        misalign = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                   ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    end

    // Load extraction: pick the addressed lane and sign/zero extend.
    always_comb begin
        rdata_shift = bus_rdata >> {addr_q[1:0], 3'b000};
        rhalf       = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_data = {24'b0, rdata_shift[7:0]};
            3'b101:  load_data = {16'b0, rhalf};
            default: load_data = bus_rdata;
        endcase
    end

    // Next-state logic for the IDLE -> BUS -> DONE handshake.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        cause_d   = cause_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    addr_d    = ex_addr;
                    funct3_d  = ex_funct3;
                    we_d      = ex_write;
                    wdata_d   = ex_write ? wdata_rep : '0;
                    wstrb_d   = ex_write ? wstrb_new : 4'b0000;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    cause_d   = 2'b00;
                    wb_data_d = '0;
                    if (!ex_read && !ex_write) begin
                        state_d   = S_DONE;
                        wb_data_d = ex_addr;
                    end else if ((ex_read && ex_write) || !f3_legal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        cause_d = 2'b11;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    end else if (misalign) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        cause_d = 2'b10;
`endif
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_ack) begin
                    state_d   = S_DONE;
                    wb_data_d = we_q ? '0 : load_data;
                end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
                    state_d   = S_DONE;
                    err_d     = 1'b1;
                    cause_d   = 2'b01;
                    wb_data_d = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers; reset discards any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0000;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            cause_q   <= 2'b00;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            cause_q   <= cause_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign (strong0, strong1) ex_ready = (state_q == S_IDLE);
    assign stall     = ex_valid & ~ex_ready;
    assign bus_req   = (state_q == S_BUS);
    assign bus_we    = (state_q == S_BUS) & we_q;
    assign bus_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign wb_valid  = (state_q == S_DONE);
    assign wb_data   = wb_data_q;
    assign err       = (state_q == S_DONE) & err_q;
    assign err_cause = cause_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed tests for mem_access with TIMEOUT=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_read = 1'b0;
    logic        ex_write = 1'b0;
    logic        ex_ready, stall, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_cause;

    int total = 0;
    int bad   = 0;

    mem_access #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_funct3(ex_funct3), .ex_read(ex_read), .ex_write(ex_write),
        .ex_ready(ex_ready), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data),
        .err(err), .err_cause(err_cause)
    );

    always #5 clk = ~clk;

    // Present one request for one cycle; returns on the falling edge after accept.
    task automatic send(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ex_valid = 1'b1; ex_read = rd; ex_write = wr;
        ex_funct3 = f3; ex_addr = a; ex_wdata = d;
        @(negedge clk);
        ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
        total++; if (wb_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_wb got=%b/%b exp=0/0", wb_valid, err); end
        total++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || wb_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus_addr, bus_wdata, wb_data); end
        total++; if (bus_wstrb !== 4'b0 || err_cause !== 2'b00 || bus_we !== 1'b0) begin bad++; $display("FAIL reset_misc got=%b/%b/%b exp=0", bus_wstrb, err_cause, bus_we); end
        $display("reset: ex_ready=%b bus_req=%b wb_valid=%b", ex_ready, bus_req, wb_valid);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sw();
        send(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin bad++; $display("FAIL sw_req got=%b/%b exp=1/1", bus_req, bus_we); end
        total++; if (bus_addr !== 32'h100 || bus_wstrb !== 4'b1111 || bus_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_bus got=%h/%b/%h exp=100/1111/deadbeef", bus_addr, bus_wstrb, bus_wdata); end
        total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL sw_ex_ready got=%b exp=0", ex_ready); end
        ex_valid = 1'b1; #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw_stall got=%b exp=1", stall); end
        ex_valid = 1'b0;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0 || err !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL sw_wb got=%b/%h/%b/%b exp=1/0/0/0", wb_valid, wb_data, err, bus_req); end
        $display("SW  addr=100 wdata=%h wstrb=1111 -> wb_valid=%b wb_data=%h", bus_wdata, wb_valid, wb_data);
        @(negedge clk);
        total++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin bad++; $display("FAIL sw_after got=%b/%b exp=0/1", wb_valid, ex_ready); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] adrs [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200, 32'h200};
        logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234, 32'h00000034};
        int          waits[6] = '{3, 3, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
            for (int w = 0; w < waits[i]; w++) begin
                total++; if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_wstrb !== 4'b0000 || bus_we !== 1'b0) begin bad++; $display("FAIL ld%0d_wait%0d got=%b/%h/%b/%b exp=1/200/0000/0", i, w, bus_req, bus_addr, bus_wstrb, bus_we); end
                @(negedge clk);
            end
            bus_ack = 1'b1; bus_rdata = 32'h80FF1234;
            total++; if (bus_req !== 1'b1 || bus_addr !== 32'h200) begin bad++; $display("FAIL ld%0d_req got=%b/%h exp=1/200", i, bus_req, bus_addr); end
            @(negedge clk);
            bus_ack = 1'b0; bus_rdata = 32'h0;
            total++; if (wb_valid !== 1'b1 || wb_data !== exps[i] || err !== 1'b0) begin bad++; $display("FAIL ld%0d_data got=%b/%h/%b exp=1/%h/0", i, wb_valid, wb_data, err, exps[i]); end
            $display("LD f3=%b addr=%h rdata=80ff1234 -> wb_data=%h", f3s[i], adrs[i], wb_data);
        end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b000};
        logic [31:0] adrs[3] = '{32'h102, 32'h102, 32'h101};
        logic [31:0] dats[3] = '{32'h000000AB, 32'h00001234, 32'h556677CD};
        logic [3:0]  stbs[3] = '{4'b0100, 4'b1100, 4'b0010};
        logic [31:0] wds [3] = '{32'hABABABAB, 32'h12341234, 32'hCDCDCDCD};
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1, f3s[i], adrs[i], dats[i]);
            total++; if (bus_wstrb !== stbs[i] || bus_wdata !== wds[i] || bus_addr !== 32'h100) begin bad++; $display("FAIL st%0d_lanes got=%b/%h/%h exp=%b/%h/100", i, bus_wstrb, bus_wdata, bus_addr, stbs[i], wds[i]); end
            bus_ack = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0;
            total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0) begin bad++; $display("FAIL st%0d_wb got=%b/%h exp=1/0", i, wb_valid, wb_data); end
            $display("ST f3=%b addr=%h -> wstrb=%b wdata=%h", f3s[i], adrs[i], bus_wstrb, bus_wdata);
        end
    endtask

    task automatic test_timeout();
        send(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        bus_rdata = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            total++; if (bus_req !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL to_cycle%0d got=%b/%b exp=1/0", c, bus_req, wb_valid); end
            @(negedge clk);
        end
        total++; if (wb_valid !== 1'b1 || err !== 1'b1 || err_cause !== 2'b01 || wb_data !== 32'h0 || bus_req !== 1'b0) begin bad++; $display("FAIL to_err got=%b/%b/%b/%h/%b exp=1/1/01/0/0", wb_valid, err, err_cause, wb_data, bus_req); end
        $display("TIMEOUT no ack -> err=%b cause=%b", err, err_cause);
        send(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        bus_rdata = 32'h11223344;
        for (int c = 0; c < 3; c++) @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        total++; if (wb_valid !== 1'b1 || err !== 1'b0 || wb_data !== 32'h11223344) begin bad++; $display("FAIL to_ackwins got=%b/%b/%h exp=1/0/11223344", wb_valid, err, wb_data); end
        $display("TIMEOUT ack on 4th cycle -> err=%b wb_data=%h", err, wb_data);
        bus_rdata = 32'h0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        total++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin bad++; $display("FAIL stray_ack got=%b/%b exp=0/1", wb_valid, ex_ready); end
        send(1'b0, 1'b0, 3'b000, 32'h55, 32'h0);
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || bus_req !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL pass got=%b/%h/%b/%b exp=1/55/0/0", wb_valid, wb_data, bus_req, err); end
        $display("PASS-THROUGH addr=55 -> wb_data=%h", wb_data);
        send(1'b1, 1'b0, 3'b011, 32'h40, 32'h0);
        total++; if (wb_valid !== 1'b1 || err !== 1'b1 || err_cause !== 2'b11 || bus_req !== 1'b0) begin bad++; $display("FAIL ill_ld got=%b/%b/%b/%b exp=1/1/11/0", wb_valid, err, err_cause, bus_req); end
        send(1'b0, 1'b1, 3'b100, 32'h40, 32'h0);
        total++; if (err !== 1'b1 || err_cause !== 2'b11 || bus_req !== 1'b0) begin bad++; $display("FAIL ill_st got=%b/%b/%b exp=1/11/0", err, err_cause, bus_req); end
        send(1'b1, 1'b1, 3'b010, 32'h40, 32'h0);
        total++; if (err !== 1'b1 || err_cause !== 2'b11 || bus_req !== 1'b0) begin bad++; $display("FAIL ill_rw got=%b/%b/%b exp=1/11/0", err, err_cause, bus_req); end
        $display("ILLEGAL cases -> err=%b cause=%b", err, err_cause);
    endtask

    task automatic test_misalign();
        send(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        total++; if (wb_valid !== 1'b1 || err !== 1'b1 || err_cause !== 2'b10 || bus_req !== 1'b0 || wb_data !== 32'h0) begin bad++; $display("FAIL mis_trap got=%b/%b/%b/%b/%h exp=1/1/10/0/0", wb_valid, err, err_cause, bus_req, wb_data); end
`else
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin bad++; $display("FAIL mis_bus got=%b/%h exp=1/100", bus_req, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_ack = 1'b0;
        total++; if (wb_valid !== 1'b1 || err !== 1'b0 || wb_data !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_ld got=%b/%b/%h exp=1/0/cafef00d", wb_valid, err, wb_data); end
`endif
        $display("LW addr=102 -> wb_valid=%b err=%b cause=%b wb_data=%h", wb_valid, err, err_cause, wb_data);
    endtask

    task automatic test_reset_mid();
        send(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b exp=1", bus_req); end
        #2 rst = 1'b1; bus_ack = 1'b1;
        #1;
        total++; if (bus_req !== 1'b0 || ex_ready !== 1'b1) begin bad++; $display("FAIL rmid_drop got=%b/%b exp=0/1", bus_req, ex_ready); end
        @(negedge clk);
        rst = 1'b0; bus_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (wb_valid !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL rmid_after%0d got=%b/%b exp=0/0", c, wb_valid, bus_req); end
        end
        $display("RESET mid-BUS -> bus_req=%b wb_valid=%b", bus_req, wb_valid);
    endtask

    initial begin
        test_reset();
        test_sw();
        test_loads();
        test_store_lanes();
        test_timeout();
        test_passthrough();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
